// File: rtl/shift_stack_pkg.sv
// shift_stack_pkg: shared operation encoding and sizing helper for the
// shift_stack LIFO and its per-level cell.
package shift_stack_pkg;

  // One decoded operation per clock; priority is resolved in the top.
  typedef enum logic [2:0] {
    OP_IDLE    = 3'd0,
    OP_WRITE   = 3'd1,
    OP_PUSH    = 3'd2,
    OP_POP     = 3'd3,
    OP_REPLACE = 3'd4
  } stack_op_t;

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_stack_cell.sv
// shift_stack_cell: one WIDTH-bit level of the shift stack. Loads from the
// level above on a push, from the level below on a pop, and from wr_data
// when it is the top level and the operation writes level 0.
module shift_stack_cell
  import shift_stack_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  stack_op_t        op_i,
  input  logic [WIDTH-1:0] above_i,
  input  logic [WIDTH-1:0] below_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             is_top_i,
  output logic [WIDTH-1:0] level_o
);

  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_d;

  // Select the next value of this level from the decoded operation.
  always_comb begin
    level_d = level_q;
    case (op_i)
      OP_PUSH: begin
        if (is_top_i) begin
          level_d = wr_data_i;
        end else begin
          level_d = above_i;
        end
      end
      OP_POP: begin
        level_d = below_i;
      end
      OP_WRITE, OP_REPLACE: begin
        if (is_top_i) begin
          level_d = wr_data_i;
        end else begin
          level_d = level_q;
        end
      end
      default: begin
        level_d = level_q;
      end
    endcase
  end

  // Level storage, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= {WIDTH{1'b0}};
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/shift_stack.sv
// shift_stack: DEPTH-level LIFO of WIDTH-bit entries built as a bidirectional
// shift register, with occupancy count, full/empty flags and one-cycle
// overflow/underflow pulses.
// Optional macro SHIFT_STACK_GUARD_EN: when defined, a push into a full stack
// is rejected (contents held) instead of dropping the bottom level.
module shift_stack
  import shift_stack_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 5,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       top_data,
  output logic [WIDTH*DEPTH-1:0] out_stack,
  output logic [CW-1:0]          count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  stack_op_t              op_s;
  stack_op_t              cell_op_s;
  logic [WIDTH*DEPTH-1:0] levels_s;
  logic [WIDTH*DEPTH-1:0] above_s;
  logic [WIDTH*DEPTH-1:0] below_s;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic                   empty_q;
  logic                   full_q;
  logic                   overflow_q;
  logic                   overflow_d;
  logic                   underflow_q;
  logic                   underflow_d;

  // Neighbour buses: level i sees level i-1 as "above" and level i+1 as
  // "below"; the ends are fed with zero so a pop zero-fills the bottom.
  assign above_s = {levels_s[WIDTH*(DEPTH-1)-1:0], {WIDTH{1'b0}}};
  assign below_s = {{WIDTH{1'b0}}, levels_s[WIDTH*DEPTH-1:WIDTH]};

  // Resolve the input strobes into one operation, by priority.
  always_comb begin
    op_s = OP_IDLE;
    if (push && pop) begin
      op_s = OP_REPLACE;
    end else if (push) begin
      op_s = OP_PUSH;
    end else if (pop) begin
      op_s = OP_POP;
    end else if (wr_en) begin
      op_s = OP_WRITE;
    end else begin
      op_s = OP_IDLE;
    end
  end

  // Derive the cell operation, next count and error pulses from the boundaries.
  always_comb begin
    cell_op_s   = op_s;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    case (op_s)
      OP_REPLACE, OP_WRITE: begin
        // Writing level 0 of an empty stack creates the first entry.
        if (empty_q) begin
          count_d = CW'(1);
        end else begin
          count_d = count_q;
        end
      end
      OP_PUSH: begin
        if (full_q) begin
          overflow_d = 1'b1;
          count_d    = count_q;
`ifdef SHIFT_STACK_GUARD_EN
          cell_op_s  = OP_IDLE;
`else
          cell_op_s  = OP_PUSH;
`endif
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty_q) begin
          underflow_d = 1'b1;
          cell_op_s   = OP_IDLE;
          count_d     = count_q;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Occupancy, flags and error pulses, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= {CW{1'b0}};
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      empty_q     <= (count_d == {CW{1'b0}});
      full_q      <= (count_d == CW'(DEPTH));
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_level
    shift_stack_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .op_i     (cell_op_s),
      .above_i  (above_s[g*WIDTH +: WIDTH]),
      .below_i  (below_s[g*WIDTH +: WIDTH]),
      .wr_data_i(wr_data),
      .is_top_i ((g == 0) ? 1'b1 : 1'b0),
      .level_o  (levels_s[g*WIDTH +: WIDTH])
    );
  end

  assign top_data  = levels_s[WIDTH-1:0];
  assign out_stack = levels_s;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
